// File: rtl/formula_1_isqrt_sched.sv
// formula_1_isqrt_sched: computes isqrt(a) + isqrt(b) + isqrt(c) with one shared,
// pipelined integer square-root unit. One argument set is accepted every three
// cycles; a, b and c are issued on consecutive cycles and the three in-order
// results are summed into a single res_vld pulse.

// ---------------------------------------------------------------------------
// isqrt: pipelined floor square root of a 32-bit unsigned value.
// The 16 digit-by-digit iterations are spread evenly across n_pipe_stages
// registered stages, so the latency from x_vld to y_vld is n_pipe_stages.
// ---------------------------------------------------------------------------
module isqrt #(
    parameter int n_pipe_stages = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        x_vld,
    input  logic [31:0] x,
    output logic        y_vld,
    output logic [15:0] y
);

    localparam int N_STEPS         = 16;
    localparam int STEPS_PER_STAGE = (N_STEPS + n_pipe_stages - 1) / n_pipe_stages;

    // Runs the restoring square-root iterations numbered [first_step, last_step)
    // on a partial remainder/root pair. Iteration k consumes bit pair
    // x[31-2k:30-2k]. Returns {remainder, root}.
    function automatic logic [35:0] sqrt_steps(
        input logic [31:0] xin,
        input logic [19:0] rem_in,
        input logic [15:0] root_in,
        input int          first_step,
        input int          last_step
    );
        logic [19:0] rem;
        logic [19:0] trial;
        logic [15:0] root;
        rem   = rem_in;
        root  = root_in;
        trial = 20'd0;
        for (int k = 0; k < N_STEPS; k++) begin
            if ((k >= first_step) && (k < last_step)) begin
                // The remainder never exceeds 2*root+1 (< 2^17), so the two
                // bits shifted out are always zero.
                rem   = {rem[17:0], xin[2*(15-k) +: 2]};
                trial = {2'b00, root, 2'b01};
                if (rem >= trial) begin
                    rem  = rem - trial;
                    root = {root[14:0], 1'b1};
                end else begin
                    root = {root[14:0], 1'b0};
                end
            end else begin
                rem  = rem;
                root = root;
            end
        end
        return {rem, root};
    endfunction

    for (genvar s = 0; s < n_pipe_stages; s++) begin : g_stage
        logic [31:0] x_in_s;
        logic [19:0] rem_in_s;
        logic [15:0] root_in_s;
        logic        vld_in_s;
        logic [19:0] rem_d;
        logic [15:0] root_d;
        logic [31:0] x_q;
        logic [19:0] rem_q;
        logic [15:0] root_q;
        logic        vld_q;

        if (s == 0) begin : g_first
            assign x_in_s    = x;
            assign rem_in_s  = 20'd0;
            assign root_in_s = 16'd0;
            assign vld_in_s  = x_vld;
        end else begin : g_next
            assign x_in_s    = g_stage[s-1].x_q;
            assign rem_in_s  = g_stage[s-1].rem_q;
            assign root_in_s = g_stage[s-1].root_q;
            assign vld_in_s  = g_stage[s-1].vld_q;
        end

        // This stage's share of the square-root iterations.
        always_comb begin
            {rem_d, root_d} = sqrt_steps(x_in_s, rem_in_s, root_in_s,
                                         s * STEPS_PER_STAGE,
                                         (s + 1) * STEPS_PER_STAGE);
        end

        // Stage register: valid is always tracked, data only moves with a valid token.
        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q  <= 1'b0;
                x_q    <= 32'd0;
                rem_q  <= 20'd0;
                root_q <= 16'd0;
            end else begin
                vld_q <= vld_in_s;
                if (vld_in_s) begin
                    x_q    <= x_in_s;
                    rem_q  <= rem_d;
                    root_q <= root_d;
                end
            end
        end
    end

    // The final remainder and operand copy are not needed downstream.
    logic unused_tail_s;
    assign unused_tail_s = ^{g_stage[n_pipe_stages-1].rem_q, g_stage[n_pipe_stages-1].x_q};

    assign y_vld = g_stage[n_pipe_stages-1].vld_q;
    assign y     = g_stage[n_pipe_stages-1].root_q;

endmodule

// ---------------------------------------------------------------------------
// Top: issue FSM feeding the shared isqrt, plus phase-driven accumulation.
// ---------------------------------------------------------------------------
module formula_1_isqrt_sched #(
    parameter int N_PIPE_STAGES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        arg_vld,
    output logic        arg_rdy,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] c,
    output logic        res_vld,
    output logic [31:0] res
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE_B = 2'd1,
        ST_ISSUE_C = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] b_q, b_d;
    logic [31:0] c_q, c_d;
    logic [1:0]  rph_q, rph_d;
    logic [17:0] acc_q, acc_d;
    logic [17:0] res_q, res_d;
    logic        res_vld_q, res_vld_d;

    logic        arg_rdy_s;
    logic        x_vld_s;
    logic [31:0] x_s;
    logic        y_vld_s;
    logic [15:0] y_s;

    // Issue side: accept a set in IDLE, then feed b and c on the next two cycles.
    always_comb begin
        state_d   = state_q;
        b_d       = b_q;
        c_d       = c_q;
        arg_rdy_s = 1'b0;
        x_vld_s   = 1'b0;
        x_s       = 32'd0;
        case (state_q)
            ST_IDLE: begin
                // Not ready while reset is held, so nothing is accepted then.
                arg_rdy_s = ~rst;
                if (arg_vld && !rst) begin
                    x_s     = a;
                    x_vld_s = 1'b1;
                    b_d     = b;
                    c_d     = c;
                    state_d = ST_ISSUE_B;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE_B: begin
                x_s     = b_q;
                x_vld_s = ~rst;
                state_d = ST_ISSUE_C;
            end
            ST_ISSUE_C: begin
                x_s     = c_q;
                x_vld_s = ~rst;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Return side: the phase counter follows y_vld alone; results arrive in issue order.
    always_comb begin
        rph_d     = rph_q;
        acc_d     = acc_q;
        res_d     = res_q;
        res_vld_d = 1'b0;
        if (y_vld_s) begin
            case (rph_q)
                2'd0: begin
                    acc_d = {2'b00, y_s};
                    rph_d = 2'd1;
                end
                2'd1: begin
                    acc_d = acc_q + {2'b00, y_s};
                    rph_d = 2'd2;
                end
                2'd2: begin
                    // At most 3 * 65535, which fits 18 bits.
                    res_d     = acc_q + {2'b00, y_s};
                    res_vld_d = 1'b1;
                    rph_d     = 2'd0;
                end
                default: begin
                    rph_d = 2'd0;
                end
            endcase
        end else begin
            rph_d = rph_q;
        end
    end

    // State, operand and accumulation registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            b_q       <= 32'd0;
            c_q       <= 32'd0;
            rph_q     <= 2'd0;
            acc_q     <= 18'd0;
            res_q     <= 18'd0;
            res_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            b_q       <= b_d;
            c_q       <= c_d;
            rph_q     <= rph_d;
            acc_q     <= acc_d;
            res_q     <= res_d;
            res_vld_q <= res_vld_d;
        end
    end

    isqrt #(
        .n_pipe_stages(N_PIPE_STAGES)
    ) u_isqrt (
        .clk  (clk),
        .rst  (rst),
        .x_vld(x_vld_s),
        .x    (x_s),
        .y_vld(y_vld_s),
        .y    (y_s)
    );

    assign arg_rdy = arg_rdy_s;
    assign res_vld = res_vld_q;
    assign res     = {14'd0, res_q};

endmodule

// File: tb/tb_formula_1_isqrt_sched.sv
// Bench for formula_1_isqrt_sched: directed sets with literal expectations plus
// randomized sets checked against a timing-aware reference model.
module tb_formula_1_isqrt_sched;

    localparam int L   = 4;
    localparam int LAT = L + 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        arg_vld;
    logic [31:0] a, b, c;
    logic        arg_rdy;
    logic        res_vld;
    logic [31:0] res;

    always #5 clk = ~clk;

    formula_1_isqrt_sched #(.N_PIPE_STAGES(L)) dut (
        .clk    (clk),
        .rst    (rst),
        .arg_vld(arg_vld),
        .arg_rdy(arg_rdy),
        .a      (a),
        .b      (b),
        .c      (c),
        .res_vld(res_vld),
        .res    (res)
    );

    typedef struct { int due; int unsigned sum; } exp_t;
    typedef struct { int acc; int unsigned val; } pin_t;

    exp_t        exp_q[$];
    pin_t        pin_q[$];
    int          cyc     = 0;
    int          next_ok = 0;
    bit          armed   = 1'b0;
    bit          done    = 1'b0;
    int unsigned exp_res = 0;
    int          n_vec   = 0;
    int          n_bad   = 0;

    // Floor square root by binary search on r*r <= v.
    function automatic int unsigned fsqrt(input logic [31:0] v);
        longint unsigned lo, hi, mid, vv;
        vv = {32'd0, v};
        lo = 0;
        hi = 65536;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (mid * mid <= vv) lo = mid;
            else hi = mid;
        end
        return int'(lo);
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d, want %0d", nm, cyc, got, want);
        end
    endtask

    // Compare process: model the expected outputs for this cycle and check them.
    always @(negedge clk) begin
        bit exp_vld;
        bit exp_rdy;
        cyc++;
        exp_vld = 1'b0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            exp_vld = 1'b1;
            exp_res = exp_q[0].sum;
            void'(exp_q.pop_front());
        end
        exp_rdy = !rst && (cyc >= next_ok);
        if (armed) begin
            chk("arg_rdy", {31'd0, arg_rdy}, {31'd0, exp_rdy});
            chk("res_vld", {31'd0, res_vld}, {31'd0, exp_vld});
            chk("res", res, exp_res);
            if (res_vld && pin_q.size() > 0 && pin_q[0].acc + LAT == cyc) begin
                chk("pinned_res", res, pin_q[0].val);
                void'(pin_q.pop_front());
            end else if (pin_q.size() > 0 && pin_q[0].acc + LAT < cyc) begin
                n_vec++;
                n_bad++;
                $display("FAIL pinned_pulse: set accepted at cycle %0d gave no pulse at cycle %0d (want res %0d)",
                         pin_q[0].acc, pin_q[0].acc + LAT, pin_q[0].val);
                void'(pin_q.pop_front());
            end
        end
        if (!rst && arg_vld && exp_rdy) begin
            exp_q.push_back('{due: cyc + LAT, sum: fsqrt(a) + fsqrt(b) + fsqrt(c)});
            next_ok = cyc + 3;
        end
        if (rst) begin
            exp_q.delete();
            exp_res = 0;
            next_ok = cyc + 1;
            armed   = 1'b1;
        end
        if (done) begin
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
            $finish;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a set and hold arg_vld until it is accepted; returns the accept cycle.
    task automatic send(input logic [31:0] xa, input logic [31:0] xb, input logic [31:0] xc,
                        output int acc);
        arg_vld = 1'b1;
        a = xa;
        b = xb;
        c = xc;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            #1;
            if (arg_rdy) begin
                acc = cyc;
                tick();
                return;
            end
            tick();
        end
        $display("FAIL send: arg_rdy never asserted within 12 cycles at cycle %0d", cyc);
        $fatal(1, "handshake stalled");
    endtask

    task automatic pinned(input logic [31:0] xa, input logic [31:0] xb, input logic [31:0] xc,
                          input int unsigned val);
        int acc;
        send(xa, xb, xc, acc);
        pin_q.push_back('{acc: acc, val: val});
    endtask

    function automatic logic [31:0] rand_arg();
        logic [31:0] r;
        case ($urandom_range(0, 3))
            0: r = $urandom_range(0, 1000);
            1: r = $urandom;
            2: begin
                r = $urandom_range(0, 65535);
                r = r * r - $urandom_range(0, 1);
            end
            default: r = 32'hFFFF_FFFF;
        endcase
        return r;
    endfunction

    initial begin
        int acc;
        int gap;
        rst     = 1'b1;
        arg_vld = 1'b0;
        a       = 32'd0;
        b       = 32'd0;
        c       = 32'd0;
        repeat (3) tick();
        rst = 1'b0;

        // Single set, then idle long enough to see res hold its value.
        pinned(32'd16, 32'd25, 32'd36, 15);
        arg_vld = 1'b0;
        repeat (12) tick();

        // Non-squares and the maximum sum.
        pinned(32'd0, 32'd1, 32'd8, 3);
        pinned(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 196605);
        arg_vld = 1'b0;
        repeat (10) tick();

        // arg_vld held high across four back-to-back sets.
        pinned(32'd1, 32'd4, 32'd9, 6);
        pinned(32'd100, 32'd100, 32'd100, 30);
        pinned(32'd2, 32'd3, 32'd5, 4);
        pinned(32'd0, 32'd0, 32'd0, 0);
        arg_vld = 1'b0;
        repeat (10) tick();

        // Different data pulsed while busy must be ignored.
        pinned(32'd7, 32'd11, 32'd13, 8);
        a = 32'hDEAD_BEEF;
        b = 32'hDEAD_BEEF;
        c = 32'hDEAD_BEEF;
        repeat (2) tick();
        arg_vld = 1'b0;
        repeat (10) tick();

        // Reset two cycles after an accept discards that set.
        send(32'd16, 32'd25, 32'd36, acc);
        arg_vld = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pinned(32'd49, 32'd64, 32'd81, 24);
        arg_vld = 1'b0;
        repeat (10) tick();

        // Random sets with random gaps.
        for (int n = 0; n < 1000; n++) begin
            gap = $urandom_range(0, 3);
            if (gap > 0) begin
                arg_vld = 1'b0;
                repeat (gap) tick();
            end
            send(rand_arg(), rand_arg(), rand_arg(), acc);
        end
        arg_vld = 1'b0;
        repeat (20) tick();
        done = 1'b1;
        repeat (3) tick();
    end

endmodule

// File: doc/formula_1_isqrt_sched.md
# formula_1_isqrt_sched

Time-multiplexed scheduler that computes isqrt(a) + isqrt(b) + isqrt(c) using a single shared pipelined `isqrt` instance instead of three. It is the area-reduced alternative to the three-instance pipelined formula_1 block: it accepts one argument set every 3 cycles through a ready/valid handshake. It issues a, b and c to the shared `isqrt` on consecutive cycles and accumulates the three in-order results into one output pulse.

## Interface
- `N_PIPE_STAGES`, default 4. Passed to the internal `isqrt` as `n_pipe_stages`. Its latency L (x_vld to y_vld) equals `N_PIPE_STAGES`.
- `clk` input, 1 bit. Single clock; all state updates on its rising edge.
- `rst` input, 1 bit. Synchronous, active-high reset.
- `arg_vld` input, 1 bit. Argument set a/b/c is valid this cycle.
- `arg_rdy` output, 1 bit. Block can accept an argument set this cycle.
- `a`, `b`, `c` input, 32 bits each. Unsigned arguments; sampled only on the accept cycle.
- `res_vld` output, 1 bit. One-cycle pulse per accepted set.
- `res` output, 32 bits. Unsigned sum, zero-extended from 18 bits. Holds its last value between pulses.

## Operation
- Exactly one `isqrt` instance. It is reset by `rst`.
- Issue FSM states:
  - IDLE: `arg_rdy`=1. When `arg_vld`=1, the set is accepted:
    - `isqrt.x` = `a` combinationally, `isqrt.x_vld`=1.
    - `b` and `c` are captured into registers.
    - Next state is ISSUE_B. Without `arg_vld`, stay in IDLE.
  - ISSUE_B: `arg_rdy`=0, `x` = b_reg, `x_vld`=1. Next state is ISSUE_C.
  - ISSUE_C: `arg_rdy`=0, `x` = c_reg, `x_vld`=1. Next state is IDLE.
- `arg_rdy` depends only on state, never on `arg_vld`.
- When `arg_rdy`=0, `arg_vld` is ignored and inputs are not sampled.
- `x_vld`=0 in IDLE when no set is accepted. `x` is don't-care when `x_vld`=0.
- Dynamic-power rules:
  - b_reg and c_reg load only on the accept cycle.
  - The accumulator and output registers load only on `y_vld`.
- Return side uses a phase counter `rph` (0..2). It advances on each `isqrt.y_vld` and wraps 2→0. On each `y_vld` the action depends on the phase:
  - Phase 0: acc ← y.
  - Phase 1: acc ← acc + y.
  - Phase 2: res_reg ← acc + y, and `res_vld` is 1 on the next cycle.
- Return side is driven only by `y_vld`. It has no cycle counter tied to the issue side, and results return in issue order.
- Width rules:
  - acc and res_reg are 18 bits; all adds are zero-extended to 18 bits.
  - Maximum sum is 3 × 65535 = 196605, so no overflow is possible.
  - `res` = {14'b0, res_reg}.
- Back-to-back sets: the next set can be accepted in the cycle after ISSUE_C. Return phases of consecutive sets do not overlap because `y_vld` preserves issue order.

## Timing
- Accept at cycle T. a is issued at T, b at T+1, c at T+2.
- y_vld for c arrives at T+2+L. `res_vld`=1 at T+3+L, so latency = L+3 (7 with default parameters).
- Throughput: one set per 3 cycles. Under continuously high `arg_vld`, `arg_rdy` pattern is 1,0,0 repeating, and `res_vld` pulses every 3rd cycle.
- Reset values:
  - FSM in IDLE, so `arg_rdy`=1 in the first cycle after reset.
  - `res_vld`=0, `res`=0, `rph`=0, acc=0.
  - `isqrt.x_vld`=0 while `rst`=1.
- `arg_rdy` is 0 while `rst`=1. `arg_vld` asserted during reset is not accepted.
- Reset mid-operation (any state, any in-flight results):
  - All in-flight work is discarded. No `res_vld` is produced for sets accepted before reset.
  - The `isqrt` valid pipeline is cleared and `rph` returns to 0.
  - The first set accepted after reset produces a correct result.

## Test plan
- Single set a=16, b=25, c=36 accepted at cycle T → `res_vld` only at T+7 (default L=4), `res`=15; `res` still 15 at T+10.
- Non-squares a=0, b=1, c=8 → `res`=3. Then a=b=c=32'hFFFF_FFFF → `res`=196605 (32'h0002_FFFD).
- `arg_vld` held high for 4 sets ({1,4,9}, {100,100,100}, {2,3,5}, {0,0,0}) → `arg_rdy` pattern 1,0,0. Sets are accepted at T, T+3, T+6, T+9. `res` = 6, 30, 4, 0, each pulse one cycle, at T+7, T+10, T+13, T+16.
- `arg_vld` pulses with different data while `arg_rdy`=0 (ISSUE_B/ISSUE_C) → those pulses are ignored. Only the accepted sets produce results, and b/c values are unchanged.
- `rst` asserted 2 cycles after accepting {16,25,36} and held 1 cycle → no `res_vld` for that set. `arg_rdy`=1 on the first cycle after reset. Next set {49,64,81} yields `res`=24 at accept+7.
- Random sets with random `arg_vld` gaps (≥1000 sets) → every accepted set yields exactly one `res_vld`, in order, with `res` = sum of floor square roots, against a scoreboard.
